// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared LSU encodings, state type and op classification helpers
package lsu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

   // func3 encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // byte-enable patterns before shifting into the addressed lane
   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   // Both directions at once, a store width that does not exist, or a load func3 outside B/H/W/BU/HU
   function automatic logic op_illegal(input logic rd, input logic wr, input logic [2:0] op);
      logic bad;
      bad = 1'b0;
      if (rd && wr)
         bad = 1'b1;
      else if (wr)
         bad = !((op == F3_B) || (op == F3_H) || (op == F3_W));
      else if (rd)
         bad = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
      return bad;
   endfunction

   // Halfwords need an even address, words a 4-byte aligned address; bytes never fault
   function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      case (op[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load lane extraction/extension
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   input  logic [2:0]  ld_op,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   output logic [31:0] ld_rdata
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Store side: enables shifted to the addressed lane, data replicated across all lanes
   always_comb begin
      st_be    = BE_W;
      st_wdata = st_data;
      case (st_size)
         2'b00: begin
            st_be    = BE_B << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = BE_H << st_addr_lo;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = BE_W;
            st_wdata = st_data;
         end
      endcase
   end

   // Load side: pick the addressed lane then sign- or zero-extend by func3
   always_comb begin
      lane_b = ld_data[7:0];
      case (ld_addr_lo)
         2'd0:    lane_b = ld_data[7:0];
         2'd1:    lane_b = ld_data[15:8];
         2'd2:    lane_b = ld_data[23:16];
         default: lane_b = ld_data[31:24];
      endcase
      lane_h = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
      case (ld_op)
         F3_B:    ld_rdata = {{24{lane_b[7]}}, lane_b};
         F3_BU:   ld_rdata = {24'd0, lane_b};
         F3_H:    ld_rdata = {{16{lane_h[15]}}, lane_h};
         F3_HU:   ld_rdata = {16'd0, lane_h};
         default: ld_rdata = ld_data;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between EX/MEM and the shared data bus
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [2:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_misalign,
   output logic        lsu_buserr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);

   // last REQ/WAIT cycle count value before the access is abandoned
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   lsu_state_t  state;
   logic [7:0]  cnt;
   logic        is_load;
   logic [2:0]  op_q;
   logic [1:0]  lo_q;

   logic        accept;
   logic        illegal;
   logic        misal;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_rdata;

   assign accept  = (state == ST_IDLE) && ex_valid && (mem_rd || mem_wr);
   assign illegal = op_illegal(mem_rd, mem_wr, mem_op);
   assign misal   = op_misaligned(mem_op, mem_addr[1:0]);

   // Hold the pipeline while an access is in flight; DONE releases it so the op retires
   assign lsu_stall = (state == ST_REQ) || (state == ST_WAIT) || accept;

   lsu_align u_align (
      .st_size    (mem_op[1:0]),
      .st_addr_lo (mem_addr[1:0]),
      .st_data    (mem_wdata),
      .ld_op      (op_q),
      .ld_addr_lo (lo_q),
      .ld_data    (bus_rdata),
      .st_be      (st_be),
      .st_wdata   (st_wdata),
      .ld_rdata   (ld_rdata)
   );

   // Sequencer FSM: checks, bus handshake, timeout counter and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= 8'd0;
         is_load      <= 1'b0;
         op_q         <= 3'd0;
         lo_q         <= 2'd0;
         lsu_done     <= 1'b0;
         lsu_rdata    <= 32'd0;
         lsu_misalign <= 1'b0;
         lsu_buserr   <= 1'b0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= 32'd0;
         bus_be       <= 4'd0;
         bus_wdata    <= 32'd0;
      end else begin
         // completion pulse and flags live for exactly the DONE cycle
         lsu_done     <= 1'b0;
         lsu_misalign <= 1'b0;
         lsu_buserr   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     state      <= ST_DONE;
                     lsu_done   <= 1'b1;
                     lsu_buserr <= 1'b1;
                  end else if (misal) begin
                     state        <= ST_DONE;
                     lsu_done     <= 1'b1;
                     lsu_misalign <= 1'b1;
                  end else begin
                     state     <= ST_REQ;
                     cnt       <= 8'd0;
                     is_load   <= mem_rd;
                     op_q      <= mem_op;
                     lo_q      <= mem_addr[1:0];
                     bus_req   <= 1'b1;
                     bus_we    <= mem_wr;
                     bus_addr  <= {mem_addr[31:2], 2'b00};
                     bus_be    <= st_be;
                     bus_wdata <= mem_wr ? st_wdata : 32'd0;
                  end
               end
            end
            ST_REQ: begin
               cnt <= cnt + 8'd1;
               if (cnt == TO_LAST) begin
                  state      <= ST_DONE;
                  bus_req    <= 1'b0;
                  lsu_done   <= 1'b1;
                  lsu_buserr <= 1'b1;
               end else if (bus_gnt) begin
                  state   <= ST_WAIT;
                  bus_req <= 1'b0;
               end
            end
            ST_WAIT: begin
               cnt <= cnt + 8'd1;
               if (bus_rvalid) begin
                  state    <= ST_DONE;
                  lsu_done <= 1'b1;
                  if (bus_err)
                     lsu_buserr <= 1'b1;
                  else if (is_load)
                     lsu_rdata <= ld_rdata;
               end else if (cnt == TO_LAST) begin
                  state      <= ST_DONE;
                  lsu_done   <= 1'b1;
                  lsu_buserr <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with directed load/store vectors
module tb_lsu_ctrl;

   typedef struct {
      logic        mis;
      logic        berr;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [2:0]  mem_op = 3'd0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        lsu_stall;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_misalign;
   logic        lsu_buserr;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        bus_err = 1'b0;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   resp_t rq[$];
   bus_t  bq[$];
   resp_t mr;
   bus_t  mb;

   int          cfg_gnt_dly = 0;
   int          cfg_rv_dly = 0;
   logic [31:0] cfg_rdata = 32'd0;
   logic        cfg_err = 1'b0;

   lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .lsu_misalign(lsu_misalign), .lsu_buserr(lsu_buserr),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // bus slave: grant after cfg_gnt_dly request cycles, respond cfg_rv_dly cycles after grant
   initial begin : responder
      int req_cnt;
      int rv_cnt;
      logic pending;
      req_cnt = 0;
      rv_cnt = 0;
      pending = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus_gnt = 1'b0;
         bus_rvalid = 1'b0;
         bus_err = 1'b0;
         bus_rdata = 32'd0;
         if (bus_req) begin
            if (req_cnt >= cfg_gnt_dly) begin
               bus_gnt = 1'b1;
               req_cnt = 0;
               pending = 1'b1;
               rv_cnt = 0;
            end else begin
               req_cnt++;
            end
         end else if (pending && cfg_rv_dly >= 0) begin
            if (rv_cnt == cfg_rv_dly) begin
               bus_rvalid = 1'b1;
               bus_rdata = cfg_rdata;
               bus_err = cfg_err;
               pending = 1'b0;
            end else begin
               rv_cnt++;
            end
         end
      end
   end

   // monitor: compare bus request fields every request cycle and each completion against the queues
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus_req) begin
               if (bq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_bus_req: addr 0x%08h with no request expected", bus_addr);
               end else begin
                  mb = bq[0];
                  chk("bus_we", 32'(bus_we), 32'(mb.we));
                  chk("bus_addr", bus_addr, mb.addr);
                  chk("bus_be", 32'(bus_be), 32'(mb.be));
                  chk("bus_wdata", bus_wdata, mb.wd);
                  if (bus_gnt) void'(bq.pop_front());
               end
            end
            if (lsu_done) begin
               done_seen++;
               if (rq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: misalign %0b buserr %0b with no op pending", lsu_misalign, lsu_buserr);
               end else begin
                  mr = rq.pop_front();
                  chk("lsu_misalign", 32'(lsu_misalign), 32'(mr.mis));
                  chk("lsu_buserr", 32'(lsu_buserr), 32'(mr.berr));
                  chk("lsu_rdata", lsu_rdata, mr.rdata);
               end
            end
         end
      end
   end

   task automatic do_op(input string name, input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] brd, input logic berr,
                        input logic has_bus, input logic [31:0] ebaddr, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic emis, input logic eberr,
                        input logic [31:0] erdata, input int elat, input int estall);
      int lat;
      int stalls;
      logic done;
      resp_t r;
      bus_t b;
      cfg_gnt_dly = gdly;
      cfg_rv_dly = rdly;
      cfg_rdata = brd;
      cfg_err = berr;
      if (has_bus) begin
         b.we = wr;
         b.addr = ebaddr;
         b.be = ebe;
         b.wd = ewd;
         bq.push_back(b);
      end
      r.mis = emis;
      r.berr = eberr;
      r.rdata = erdata;
      rq.push_back(r);
      @(posedge clk);
      #1;
      ex_valid = 1'b1;
      mem_rd = rd;
      mem_wr = wr;
      mem_op = op;
      mem_addr = addr;
      mem_wdata = wd;
      lat = 0;
      stalls = 0;
      done = 1'b0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lsu_stall) stalls++;
         if (lsu_done) done = 1'b1;
      end
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no lsu_done within 100 cycles", name);
      end else begin
         chk({name, "_latency"}, 32'(lat), 32'(elat));
         chk({name, "_stall_cycles"}, 32'(stalls), 32'(estall));
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int base;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_bus_req", 32'(bus_req), 32'd0);
      chk("reset_lsu_done", 32'(lsu_done), 32'd0);
      chk("reset_lsu_stall", 32'(lsu_stall), 32'd0);
      chk("reset_lsu_rdata", lsu_rdata, 32'd0);
      chk("reset_bus_be", 32'(bus_be), 32'd0);
      chk("reset_bus_addr", bus_addr, 32'd0);

      //     name   rd wr  op      addr          wdata         g  r  bus_rdata     err bus baddr         be       bwdata        mis berr rdata         lat st
      do_op("sw",   0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 1, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'h0000_0000, 4, 3);
      do_op("lb",   1, 0, 3'b000, 32'h0000_2003, 32'h5555_5555, 0, 0, 32'h80FF_FF7F, 0, 1, 32'h0000_2000, 4'b1000, 32'h0,         0, 0, 32'hFFFF_FF80, 4, 3);
      do_op("lbu",  1, 0, 3'b100, 32'h0000_2003, 32'h0,         0, 0, 32'h80FF_FF7F, 0, 1, 32'h0000_2000, 4'b1000, 32'h0,         0, 0, 32'h0000_0080, 4, 3);
      do_op("lhu",  1, 0, 3'b101, 32'h0000_2002, 32'h0,         0, 0, 32'h80FF_FF7F, 0, 1, 32'h0000_2000, 4'b1100, 32'h0,         0, 0, 32'h0000_80FF, 4, 3);
      do_op("lh",   1, 0, 3'b001, 32'h0000_2000, 32'h0,         0, 0, 32'h80FF_FF7F, 0, 1, 32'h0000_2000, 4'b0011, 32'h0,         0, 0, 32'hFFFF_FF7F, 4, 3);
      do_op("lw",   1, 0, 3'b010, 32'h0000_2000, 32'h0,         0, 0, 32'h80FF_FF7F, 0, 1, 32'h0000_2000, 4'b1111, 32'h0,         0, 0, 32'h80FF_FF7F, 4, 3);
      do_op("lh_err",1,0, 3'b001, 32'h0000_2002, 32'h0,         0, 0, 32'h1234_5678, 1, 1, 32'h0000_2000, 4'b1100, 32'h0,         0, 1, 32'h80FF_FF7F, 4, 3);
      do_op("lw_mis",1,0, 3'b010, 32'h0000_3002, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         1, 0, 32'h80FF_FF7F, 2, 1);
      do_op("sh_mis",0,1, 3'b001, 32'h0000_0011, 32'hAAAA_BBBB, 0, 0, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         1, 0, 32'h80FF_FF7F, 2, 1);
      do_op("sb_slow",0,1,3'b000, 32'h0000_0041, 32'h1234_56A5, 5, 0, 32'h0,        0, 1, 32'h0000_0040, 4'b0010, 32'hA5A5_A5A5, 0, 0, 32'h80FF_FF7F, 9, 8);

      // response never arrives inside the window; the late rvalid must not produce another completion
      do_op("lw_tmo",1, 0, 3'b010, 32'h0000_4000, 32'h0,        0, 10, 32'hCAFE_F00D, 0, 1, 32'h0000_4000, 4'b1111, 32'h0,        0, 1, 32'h80FF_FF7F, 10, 9);
      base = done_seen;
      repeat (12) @(negedge clk);
      chk("late_rvalid_ignored", 32'(done_seen - base), 32'd0);

      do_op("rdwr", 1, 1, 3'b010, 32'h0000_5002, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         0, 1, 32'h80FF_FF7F, 2, 1);
      do_op("ld011",1, 0, 3'b011, 32'h0000_5000, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         0, 1, 32'h80FF_FF7F, 2, 1);
      do_op("st100",0, 1, 3'b100, 32'h0000_5001, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,         4'b0000, 32'h0,         0, 1, 32'h80FF_FF7F, 2, 1);

      // reset while waiting for the response: everything clears, the stale rvalid is dropped
      begin
         bus_t b;
         b.we = 1'b0;
         b.addr = 32'h0000_7000;
         b.be = 4'b1111;
         b.wd = 32'h0;
         bq.push_back(b);
         cfg_gnt_dly = 0;
         cfg_rv_dly = 4;
         cfg_rdata = 32'h1111_2222;
         cfg_err = 1'b0;
         @(posedge clk);
         #1;
         ex_valid = 1'b1;
         mem_rd = 1'b1;
         mem_wr = 1'b0;
         mem_op = 3'b010;
         mem_addr = 32'h0000_7000;
         @(posedge clk);
         @(posedge clk);
         #2;
         rst = 1'b1;
         ex_valid = 1'b0;
         mem_rd = 1'b0;
         #1;
         chk("rst_bus_req", 32'(bus_req), 32'd0);
         chk("rst_lsu_stall", 32'(lsu_stall), 32'd0);
         chk("rst_lsu_done", 32'(lsu_done), 32'd0);
         chk("rst_bus_be", 32'(bus_be), 32'd0);
         chk("rst_bus_addr", bus_addr, 32'd0);
         chk("rst_lsu_rdata", lsu_rdata, 32'd0);
         @(posedge clk);
         @(posedge clk);
         #1;
         rst = 1'b0;
         base = done_seen;
         repeat (8) @(negedge clk);
         chk("stale_rvalid_ignored", 32'(done_seen - base), 32'd0);
      end

      do_op("sw_post",0,1, 3'b010, 32'h0000_6000, 32'h0BAD_F00D, 0, 0, 32'h0,       0, 1, 32'h0000_6000, 4'b1111, 32'h0BAD_F00D, 0, 0, 32'h0000_0000, 4, 3);

      repeat (3) @(negedge clk);
      chk("resp_queue_drained", 32'(rq.size()), 32'd0);
      chk("bus_queue_drained", 32'(bq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
